// File: rtl/calificare_pkg.sv
// Shared definitions for the sensor qualifier: state encoding and default tick counts.
package calificare_pkg;

    typedef enum logic [1:0] {
        INACTIV    = 2'd0,
        CONFIRMARE = 2'd1,
        ACTIV      = 2'd2,
        ELIBERARE  = 2'd3
    } stare_t;

    localparam int ON_TICKS_IMPLICIT  = 3;
    localparam int OFF_TICKS_IMPLICIT = 4;
    localparam int CNT_W_IMPLICIT     = 3;

endpackage

// File: rtl/sincronizator_2ff.sv
// Two-flop synchronizer for bringing an asynchronous sensor level into the clk domain.
module sincronizator_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/calificare_semnal.sv
// Sensor-input qualifier with on-delay / off-hold hysteresis and one-cycle edge pulses.
// Define CALIFICARE_SYNC_EN to route semnal through a two-flop synchronizer first.
module calificare_semnal
    import calificare_pkg::*;
#(
    parameter int ON_TICKS  = ON_TICKS_IMPLICIT,
    parameter int OFF_TICKS = OFF_TICKS_IMPLICIT,
    parameter int CNT_W     = CNT_W_IMPLICIT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic semnal,
    output logic semnal_out,
    output logic puls_activare,
    output logic puls_dezactivare
);

    logic s;

`ifdef CALIFICARE_SYNC_EN
    sincronizator_2ff u_sincronizator (
        .clk (clk),
        .rst (rst),
        .d   (semnal),
        .q   (s)
    );
`else
    assign s = semnal;
`endif

    stare_t           stare, stare_urm;
    logic [CNT_W-1:0] cnt, cnt_urm;
    logic [CNT_W:0]   cnt_plus;
    logic             out_urm, act_urm, dez_urm;

    // Extra bit keeps the terminal-count compare free of wrap-around.
    assign cnt_plus = {1'b0, cnt} + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stare            <= INACTIV;
            cnt              <= '0;
            semnal_out       <= 1'b0;
            puls_activare    <= 1'b0;
            puls_dezactivare <= 1'b0;
        end else begin
            stare            <= stare_urm;
            cnt              <= cnt_urm;
            semnal_out       <= out_urm;
            puls_activare    <= act_urm;
            puls_dezactivare <= dez_urm;
        end
    end

    // A level change of s always wins over a tick arriving in the same cycle.
    always_comb begin
        stare_urm = stare;
        cnt_urm   = cnt;
        act_urm   = 1'b0;
        dez_urm   = 1'b0;
        case (stare)
            INACTIV: begin
                cnt_urm = '0;
                if (s) stare_urm = CONFIRMARE;
            end
            CONFIRMARE: begin
                if (!s) begin
                    stare_urm = INACTIV;
                    cnt_urm   = '0;
                end else if (tick) begin
                    if (cnt_plus == (CNT_W+1)'(ON_TICKS)) begin
                        stare_urm = ACTIV;
                        cnt_urm   = '0;
                        act_urm   = 1'b1;
                    end else begin
                        cnt_urm = cnt_plus[CNT_W-1:0];
                    end
                end
            end
            ACTIV: begin
                cnt_urm = '0;
                if (!s) stare_urm = ELIBERARE;
            end
            ELIBERARE: begin
                if (s) begin
                    stare_urm = ACTIV;
                    cnt_urm   = '0;
                end else if (tick) begin
                    if (cnt_plus == (CNT_W+1)'(OFF_TICKS)) begin
                        stare_urm = INACTIV;
                        cnt_urm   = '0;
                        dez_urm   = 1'b1;
                    end else begin
                        cnt_urm = cnt_plus[CNT_W-1:0];
                    end
                end
            end
            default: begin
                stare_urm = INACTIV;
                cnt_urm   = '0;
            end
        endcase
        out_urm = (stare_urm == ACTIV) || (stare_urm == ELIBERARE);
    end

endmodule
